// File: rtl/clkdiv_multi.sv
// -----------------------------------------------------------------------------
// clkdiv_multi
//   Multi-channel, runtime-programmable clock divider. Every channel divides the
//   single system clock by its own ratio d and produces a registered square wave
//   (low for floor(d/2) cycles, high for ceil(d/2) cycles) and a one-cycle tick
//   in the last cycle of each period. A new ratio is held in a shadow register
//   and only takes over at a period boundary, so no period is ever shortened.
//
//   d = 0 : channel disabled (tick 0, clk_out 0, counter parked at 0)
//   d = 1 : tick every cycle, clk_out held 0
//   d >= 2: counter runs 0..d-1
//
// Ports
//   clk        system clock (only clock)
//   rst_n      asynchronous active-low reset
//   cfg_valid  ratio-write request
//   cfg_ready  addressed channel can take a new ratio (no update pending);
//              always 1 for an out-of-range cfg_ch (the write is dropped)
//   cfg_ch     target channel index
//   cfg_div    new divide ratio
//   sync_i     phase-align all channels (only with CLKDIV_SYNC_EN)
//   tick       per-channel one-cycle enable
//   clk_out    per-channel registered divided clock
//
// Build option
//   CLKDIV_SYNC_EN  when defined, sync_i restarts every channel at count 0 and
//                   applies any pending ratio at once; otherwise sync_i is
//                   ignored.
// -----------------------------------------------------------------------------
module clkdiv_multi #(
  parameter int  CHANNELS  = 4,
  parameter int  DIV_W     = 16,
  parameter int  RESET_DIV = 2,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                sync_i,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  // Count at which the square wave goes high (floor division, so odd ratios
  // give the extra cycle to the high phase).
  function automatic logic [DIV_W-1:0] half_ratio(input logic [DIV_W-1:0] d);
    return d >> 1;
  endfunction

  logic [CHANNELS-1:0] pend_vec;
  logic [CHANNELS-1:0] wr_vec;
  logic                sync_en;

`ifdef CLKDIV_SYNC_EN
  assign sync_en = sync_i;
`else
  assign sync_en = 1'b0;
  logic unused_sync;
  assign unused_sync = sync_i;
`endif

  // Out-of-range channel indices match no channel, leaving ready at 1 and the
  // write enable at 0.
  always_comb begin
    cfg_ready = 1'b1;
    wr_vec    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_vec[i];
    end
    for (int i = 0; i < CHANNELS; i++) begin
      wr_vec[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] cnt_nxt;
    logic             pend;
    logic             clk_q;
    logic             at_last;
    logic             wrap;
    logic             clk_nxt;

    // at_last doubles as the tick: it decodes registered state only.
    // Ratios 0 and 1 are "always at wrap" so a pending update lands on the
    // very next edge.
    always_comb begin
      at_last = (active != '0) && (cnt == active - ONE);
      wrap    = (active <= ONE) || at_last;
      cnt_nxt = wrap ? '0 : cnt + ONE;
      clk_nxt = (active > ONE) && (cnt_nxt >= half_ratio(active));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        active <= RST_DIV;
        shadow <= RST_DIV;
        pend   <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        if (sync_en) begin
          cnt   <= '0;
          clk_q <= 1'b0;
          if (pend) begin
            active <= shadow;
            pend   <= 1'b0;
          end
        end else if (pend && wrap) begin
          // Apply at the boundary; the new period starts from count 0, which
          // is always in the low phase.
          active <= shadow;
          cnt    <= '0;
          clk_q  <= 1'b0;
          pend   <= 1'b0;
        end else begin
          cnt   <= cnt_nxt;
          clk_q <= clk_nxt;
        end
        // A transfer only happens while pend is clear, so it never collides
        // with an apply; placed last so it wins over a same-edge sync.
        if (wr_vec[g]) begin
          shadow <= cfg_div;
          pend   <= 1'b1;
        end
      end
    end

    assign tick[g]     = at_last;
    assign clk_out[g]  = clk_q;
    assign pend_vec[g] = pend;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_multi
//   Scoreboard bench for clkdiv_multi. Directed phases push the hand-computed
//   cycle numbers of expected ticks into per-channel queues; a monitor on the
//   falling edge pops and compares whenever an enabled channel ticks. Square
//   wave levels and cfg_ready are compared directly at chosen cycles.
//   Cycle numbers count rising edges since the last reset release.
//   A second instance with CHANNELS = 5 gives a 3-bit cfg_ch, so the
//   out-of-range index 7 can actually be driven.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clkdiv_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic        sync_i = 1'b0;
  logic [3:0]  tick;
  logic [3:0]  clk_out;

  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [2:0]  w_ch = '0;
  logic [15:0] w_div = '0;
  logic [4:0]  w_tick;
  logic [4:0]  w_clk;

  int          cyc;
  int          checks = 0;
  int          errors = 0;
  bit [3:0]    mon_en = '0;
  int          exp_q[4][$];

  clkdiv_multi #(.CHANNELS(4), .DIV_W(16), .RESET_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sync_i(sync_i),
    .tick(tick), .clk_out(clk_out)
  );

  clkdiv_multi #(.CHANNELS(5), .DIV_W(16), .RESET_DIV(2)) u_wide (
    .clk(clk), .rst_n(rst_n), .cfg_valid(w_valid), .cfg_ready(w_ready),
    .cfg_ch(w_ch), .cfg_div(w_div), .sync_i(sync_i),
    .tick(w_tick), .clk_out(w_clk)
  );

  always #10 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Tick monitor: pops one expected cycle per observed tick.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (mon_en[i] && tick[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected tick ch%0d", i), cyc, 32'hFFFF_FFFF);
          end else begin
            int e;
            e = exp_q[i].pop_front();
            chk($sformatf("tick ch%0d", i), cyc, e);
          end
        end
      end
    end
  end

  task automatic goto(input int c);
    int guard = 0;
    while (cyc < c && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) chk("cycle alignment", cyc, c);
  endtask

  task automatic mon_on(input int ch);
    #1;
    exp_q[ch].delete();
    mon_en[ch] = 1'b1;
  endtask

  task automatic push(input int ch, input int c);
    exp_q[ch].push_back(c);
  endtask

  task automatic mon_off(input int ch);
    #1;
    chk($sformatf("missed ticks ch%0d", ch), exp_q[ch].size(), 0);
    mon_en[ch] = 1'b0;
    exp_q[ch].delete();
  endtask

  // Called in the low phase of cycle c; transfer happens at edge c+1 and the
  // task returns at the falling edge of cycle c+1.
  task automatic cfg_write(input int ch, input int div);
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(div);
    cfg_valid = 1'b1;
    #1 chk($sformatf("cfg_ready before write ch%0d", ch), cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while the reset is held
    repeat (3) @(negedge clk);
    #1;
    chk("reset tick", tick, 0);
    chk("reset clk_out", clk_out, 0);
    chk("reset wide tick", w_tick, 0);
    for (int k = 0; k < 4; k++) begin
      cfg_ch = 2'(k);
      #1 chk($sformatf("reset cfg_ready ch%0d", k), cfg_ready, 1);
    end
    rst_n = 1'b1;

    // ch0 at the reset ratio 2
    mon_on(0);
    for (int c = 1; c <= 11; c += 2) push(0, c);
    for (int c = 1; c <= 8; c++) begin
      goto(c);
      chk("clk_out ch0 d=2", clk_out[0], c % 2);
      if (c == 2) begin
        for (int k = 0; k < 4; k++) begin
          cfg_ch = 2'(k);
          #1 chk($sformatf("idle cfg_ready ch%0d", k), cfg_ready, 1);
        end
      end
    end
    goto(11);
    mon_off(0);

    // ch1 -> 5: last d=2 tick at 13, apply at edge 14
    goto(12);
    mon_on(1);
    push(1, 13); push(1, 18); push(1, 23); push(1, 28);
    cfg_write(1, 5);
    #1 chk("cfg_ready ch1 pending", cfg_ready, 0);
    for (int c = 14; c <= 23; c++) begin
      goto(c);
      if (c == 14) #1 chk("cfg_ready ch1 after apply", cfg_ready, 1);
      chk("clk_out ch1 d=5", clk_out[1], ((c - 14) % 5) >= 2);
    end
    goto(28);
    mon_off(1);

    // ch2 -> 8 (applies at 32), then -> 3 mid-period
    goto(30);
    cfg_write(2, 8);
    goto(33);
    mon_on(2);
    push(2, 39); push(2, 42); push(2, 45); push(2, 48);
    goto(34);
    cfg_write(2, 3);
    #1 chk("cfg_ready ch2 pending 35", cfg_ready, 0);
    chk("clk_out ch2 d=8 low", clk_out[2], 0);
    goto(36);
    chk("clk_out ch2 d=8 high", clk_out[2], 1);
    goto(37);
    #1 chk("cfg_ready ch2 pending 37", cfg_ready, 0);
    goto(39);
    #1 chk("cfg_ready ch2 pending 39", cfg_ready, 0);
    goto(40);
    #1 chk("cfg_ready ch2 after apply", cfg_ready, 1);
    chk("clk_out ch2 d=3 cnt0", clk_out[2], 0);
    goto(41);
    chk("clk_out ch2 d=3 cnt1", clk_out[2], 1);
    goto(48);
    mon_off(2);

    // ch3 -> 0 (disabled after tick 51), then -> 1
    goto(50);
    mon_on(3);
    push(3, 51);
    cfg_write(3, 0);
    for (int c = 52; c <= 55; c++) begin
      goto(c);
      chk("clk_out ch3 disabled", clk_out[3], 0);
      chk("tick ch3 disabled", tick[3], 0);
    end
    goto(58);
    mon_off(3);
    cfg_write(3, 1);
    #1 chk("cfg_ready ch3 pending", cfg_ready, 0);
    mon_on(3);
    for (int c = 60; c <= 63; c++) push(3, c);
    goto(60);
    #1 chk("cfg_ready ch3 after apply", cfg_ready, 1);
    for (int c = 60; c <= 63; c++) begin
      goto(c);
      chk("clk_out ch3 d=1", clk_out[3], 0);
    end
    goto(63);
    mon_off(3);

    // Out-of-range channel on the 5-channel instance
    goto(66);
    w_ch = 3'd7; w_div = 16'd9; w_valid = 1'b1;
    #1 chk("cfg_ready out-of-range", w_ready, 1);
    @(negedge clk);
    w_valid = 1'b0;
    goto(68);
    for (int k = 0; k < 5; k++) begin
      w_ch = 3'(k);
      #1 chk($sformatf("wide cfg_ready ch%0d after drop", k), w_ready, 1);
    end
    for (int c = 68; c <= 71; c++) begin
      goto(c);
      chk("wide tick unchanged", w_tick, (c % 2) ? 5'h1F : 5'h00);
    end

`ifdef CLKDIV_SYNC_EN
    // Program 4,6,7,9 then sync at edge 77
    goto(72);
    cfg_write(0, 4);
    cfg_write(1, 6);
    cfg_write(2, 7);
    cfg_write(3, 9);
    sync_i = 1'b1;
    goto(77);
    sync_i = 1'b0;
    #1;
    chk("clk_out after sync", clk_out, 0);
    chk("tick after sync", tick, 0);
    for (int k = 0; k < 4; k++) mon_on(k);
    push(0, 80); push(0, 84); push(0, 88); push(0, 92);
    push(1, 82); push(1, 88); push(1, 94);
    push(2, 83); push(2, 90);
    push(3, 85); push(3, 94);
    goto(94);
    for (int k = 0; k < 4; k++) mon_off(k);
`else
    // sync_i has no effect in this build
    goto(72);
    mon_on(0);
    push(0, 73); push(0, 75); push(0, 77); push(0, 79);
    goto(74);
    sync_i = 1'b1;
    goto(75);
    sync_i = 1'b0;
    chk("clk_out ch0 sync ignored 75", clk_out[0], 1);
    goto(77);
    chk("clk_out ch0 sync ignored 77", clk_out[0], 1);
    goto(79);
    mon_off(0);
`endif

    // Asynchronous reset mid-period with an update pending on ch2
    goto(95);
    cfg_write(2, 5);
    #1 chk("cfg_ready ch2 pending before reset", cfg_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset tick", tick, 0);
    chk("async reset clk_out", clk_out, 0);
    chk("async reset cfg_ready ch2", cfg_ready, 1);
    chk("async reset wide tick", w_tick, 0);
    chk("async reset wide clk_out", w_clk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_on(0);
    push(0, 1); push(0, 3); push(0, 5);
    goto(1);
    chk("tick after re-reset", tick, 4'hF);
    chk("wide tick after re-reset", w_tick, 5'h1F);
    goto(2);
    chk("tick low after re-reset", tick, 4'h0);
    goto(5);
    mon_off(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
